// File: rtl/vec_pkg.sv
// Shared types for the 6-lane vector datapath: lane geometry, ALU opcodes,
// operand modes and the pipelined control bundle.
package vec_pkg;

  localparam int L      = 6;
  localparam int LANE_W = 8;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [L-1:0]     vec_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SHL   = 3'b101,
    ALU_MUL   = 3'b110,
    ALU_PASSB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    VSI_VV = 2'b00,
    VSI_VS = 2'b01,
    VSI_VI = 2'b10,
    VSI_SC = 2'b11
  } vsi_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic flags_write;
  } ctrl_t;

endpackage

// File: rtl/vec_alu_lane.sv
// One ALU lane: modulo-2^N arithmetic/logic op plus {N,Z} flags.
module vec_alu_lane
  import vec_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic [1:0]   flags
);

  always_comb begin
    // NOTE: a default assignment up front keeps this block from inferring a latch.
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SHL:   result = a << 1;
      ALU_MUL:   result = a * b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign flags = {result[N-1], result == '0};

endmodule

// File: rtl/vec_datapath.sv
// Five-stage F/D/E/M/W SIMD datapath: 16 x 6-lane register file with
// write-through, six ALU lanes, lane-0 memory address/data port.
module vec_datapath
  import vec_pkg::*;
#(
  parameter int I = 32,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           RegWrite,
  input  logic [1:0]     VSIFlag,
  input  logic           MemtoReg,
  input  logic           MemWrite,
  input  logic           FlagsWrite,
  input  logic           RegSrc,
  input  logic [2:0]     ALUControl,
  input  logic [I-1:0]   InstrF,
  input  logic [I-1:0]   ReadData,
  input  logic [I-1:0]   PCNext,
  output logic           MemWriteM,
  output logic           FlagsWriteW,
  output logic           MemtoRegM,
  output logic [2*L-1:0] ALUFlagsW,
  output logic [I-1:0]   InstrD,
  output logic [N-1:0]   ALUOutM,
  output logic [N-1:0]   WriteDataM,
  output logic [I-1:0]   A
);

  typedef logic [L-1:0][N-1:0] vecn_t;
  typedef logic [L-1:0][1:0]   flagv_t;

  // Decode stage
  logic [3:0] rn, rd, rm, ra2;
  vecn_t      rd1, rd2, srcb, pc_vec;
  ctrl_t      ctrl_d;

  // Execute stage
  vecn_t      srca_e, srcb_e, alu_res, res_e;
  flagv_t     alu_flags, flags_e;
  logic [2:0] op_e;
  logic       scalar_e;
  ctrl_t      ctrl_e;
  logic [3:0] rd_e;
  logic [N-1:0] wd_e;

  // Memory stage
  vecn_t      res_m;
  flagv_t     flags_m;
  ctrl_t      ctrl_m;
  logic [3:0] rd_m;
  logic [N-1:0] wd_m;

  // Writeback stage
  vecn_t      res_w, wb_w;
  flagv_t     flags_w;
  ctrl_t      ctrl_w;
  logic [3:0] rd_w;
  logic [N-1:0] read_data_w;

  vecn_t rf [16];

  logic unused_read_data;
  assign unused_read_data = ^ReadData[I-1:N];

  // Fetch -> decode
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is always updated with non-blocking assignments.
    if (!reset) InstrD <= '0;
    else        InstrD <= InstrF;
  end

  assign rn     = InstrD[19:16];
  assign rd     = InstrD[15:12];
  assign rm     = InstrD[3:0];
  assign ra2    = RegSrc ? rd : rm;
  assign pc_vec = (L*N)'(PCNext);
  assign ctrl_d = '{reg_write: RegWrite, mem_to_reg: MemtoReg,
                    mem_write: MemWrite, flags_write: FlagsWrite};

  // R15 reads the next PC; a register being written back this cycle is bypassed.
  function automatic vecn_t read_reg(input logic [3:0] addr);
    vecn_t v;
    if (addr == 4'd15)                       v = pc_vec;
    else if (ctrl_w.reg_write && rd_w == addr) v = wb_w;
    else                                     v = rf[addr];
    return v;
  endfunction

  always_comb begin
    rd1 = read_reg(rn);
    rd2 = read_reg(ra2);
  end

  always_comb begin
    srcb = rd2;
    case (vsi_e'(VSIFlag))
      VSI_VS:  srcb = {L{rd2[0]}};
      VSI_VI:  srcb = {L{InstrD[N-1:0]}};
      default: srcb = rd2;
    endcase
  end

  assign A = I'(rd1);

  // Decode -> execute
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srca_e   <= '0;
      srcb_e   <= '0;
      op_e     <= '0;
      scalar_e <= 1'b0;
      ctrl_e   <= '0;
      rd_e     <= '0;
      wd_e     <= '0;
    end else begin
      srca_e   <= rd1;
      srcb_e   <= srcb;
      op_e     <= ALUControl;
      scalar_e <= (vsi_e'(VSIFlag) == VSI_SC);
      ctrl_e   <= ctrl_d;
      rd_e     <= rd;
      wd_e     <= rd2[0];
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lane
    vec_alu_lane #(.N(N)) u_lane (
      .op     (op_e),
      .a      (srca_e[k]),
      .b      (srcb_e[k]),
      .result (alu_res[k]),
      .flags  (alu_flags[k])
    );
  end

  // Scalar mode keeps only lane 0 alive.
  always_comb begin
    res_e   = alu_res;
    flags_e = alu_flags;
    if (scalar_e) begin
      for (int k = 1; k < L; k++) begin
        res_e[k]   = '0;
        flags_e[k] = '0;
      end
    end
  end

  // Execute -> memory -> writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_m       <= '0;
      flags_m     <= '0;
      ctrl_m      <= '0;
      rd_m        <= '0;
      wd_m        <= '0;
      res_w       <= '0;
      flags_w     <= '0;
      ctrl_w      <= '0;
      rd_w        <= '0;
      read_data_w <= '0;
    end else begin
      res_m       <= res_e;
      flags_m     <= flags_e;
      ctrl_m      <= ctrl_e;
      rd_m        <= rd_e;
      wd_m        <= wd_e;
      res_w       <= res_m;
      flags_w     <= flags_m;
      ctrl_w      <= ctrl_m;
      rd_w        <= rd_m;
      read_data_w <= ReadData[N-1:0];
    end
  end

  always_comb begin
    wb_w = res_w;
    if (ctrl_w.mem_to_reg) begin
      wb_w    = '0;
      wb_w[0] = read_data_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the register file is cleared on reset because software relies on zeroed registers.
    if (!reset) begin
      for (int r = 0; r < 16; r++) rf[r] <= '0;
    end else if (ctrl_w.reg_write && rd_w != 4'd15) begin
      rf[rd_w] <= wb_w;
    end
  end

  assign MemWriteM   = ctrl_m.mem_write;
  assign MemtoRegM   = ctrl_m.mem_to_reg;
  assign ALUOutM     = res_m[0];
  assign WriteDataM  = wd_m;
  assign FlagsWriteW = ctrl_w.flags_write;
  assign ALUFlagsW   = flags_w;

endmodule

// File: tb/tb_vec_datapath.sv
// Self-checking bench for vec_datapath: directed scenarios then random
// instructions against a lane-level arithmetic model of the register file.
module tb_vec_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc;
  logic [1:0]  VSIFlag;
  logic [2:0]  ALUControl;
  logic [31:0] InstrF, ReadData, PCNext;
  logic        MemWriteM, FlagsWriteW, MemtoRegM;
  logic [11:0] ALUFlagsW;
  logic [31:0] InstrD, A;
  logic [7:0]  ALUOutM, WriteDataM;

  vec_datapath #(.I(32), .N(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .RegWrite    (RegWrite),
    .VSIFlag     (VSIFlag),
    .MemtoReg    (MemtoReg),
    .MemWrite    (MemWrite),
    .FlagsWrite  (FlagsWrite),
    .RegSrc      (RegSrc),
    .ALUControl  (ALUControl),
    .InstrF      (InstrF),
    .ReadData    (ReadData),
    .PCNext      (PCNext),
    .MemWriteM   (MemWriteM),
    .FlagsWriteW (FlagsWriteW),
    .MemtoRegM   (MemtoRegM),
    .ALUFlagsW   (ALUFlagsW),
    .InstrD      (InstrD),
    .ALUOutM     (ALUOutM),
    .WriteDataM  (WriteDataM),
    .A           (A)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Architectural model: register contents as integer lanes
  int regs [16][6];
  bit pend_valid;
  bit pend_rw, pend_m2r, pend_fw;
  int pend_rd, pend_flags, pend_rdata;
  int pend_res [6];
  logic [31:0] obs_a, obs_flags_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rd_lane(int r, int k, logic [31:0] pc);
    if (r == 15) return (k < 4) ? int'((pc >> (8 * k)) & 32'hFF) : 0;
    return regs[r][k];
  endfunction

  function automatic int alu(int op, int a, int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a * 2;
      6: r = a * b;
      default: r = b;
    endcase
    return r & 255;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 6; k++) regs[r][k] = 0;
    pend_valid = 1'b0;
  endtask

  task automatic set_ctrl(input bit rw, m2r, mw, fw, rs, input logic [1:0] vsi, input logic [2:0] op);
    RegWrite = rw; MemtoReg = m2r; MemWrite = mw; FlagsWrite = fw;
    RegSrc = rs; VSIFlag = vsi; ALUControl = op;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_memwrite_m"},  32'(MemWriteM), 32'h0);
    check({tag, "_flagswrite_w"}, 32'(FlagsWriteW), 32'h0);
    check({tag, "_memtoreg_m"},  32'(MemtoRegM), 32'h0);
    check({tag, "_aluflags_w"},  32'(ALUFlagsW), 32'h0);
    check({tag, "_instr_d"},     InstrD, 32'h0);
    check({tag, "_aluout_m"},    32'(ALUOutM), 32'h0);
    check({tag, "_writedata_m"}, 32'(WriteDataM), 32'h0);
    check({tag, "_a"},           A, 32'h0);
  endtask

  // Called in the W cycle of the pending instruction.
  task automatic retire();
    if (pend_valid) begin
      check("flagswrite_w", 32'(FlagsWriteW), 32'(pend_fw));
      check("aluflags_w", 32'(ALUFlagsW), 32'(pend_flags));
      obs_flags_prev = 32'(ALUFlagsW);
      if (pend_rw && pend_rd != 15)
        for (int k = 0; k < 6; k++)
          regs[pend_rd][k] = pend_m2r ? ((k == 0) ? (pend_rdata & 255) : 0) : pend_res[k];
      pend_valid = 1'b0;
    end
  endtask

  // D, E, M cycles of one instruction; its W cycle overlaps the next D.
  task automatic issue(input logic [31:0] instr, input bit rw, m2r, mw, fw, rs,
                       input logic [1:0] vsi, input logic [2:0] op,
                       input logic [31:0] pc, input logic [31:0] rdata);
    int rn, rdd, rm, imm, ra2, flags, nf, zf;
    int sa [6];
    int sb [6];
    int b2 [6];
    int res [6];
    logic [31:0] a_exp;
    InstrF = instr;
    step();
    retire();
    check("instr_d", InstrD, instr);
    set_ctrl(rw, m2r, mw, fw, rs, vsi, op);
    PCNext = pc;
    rn  = int'(instr[19:16]);
    rdd = int'(instr[15:12]);
    rm  = int'(instr[3:0]);
    imm = int'(instr[7:0]);
    ra2 = rs ? rdd : rm;
    flags = 0;
    for (int k = 0; k < 6; k++) begin
      sa[k] = rd_lane(rn, k, pc);
      b2[k] = rd_lane(ra2, k, pc);
    end
    for (int k = 0; k < 6; k++) begin
      case (vsi)
        2'b01:   sb[k] = b2[0];
        2'b10:   sb[k] = imm;
        default: sb[k] = b2[k];
      endcase
      res[k] = alu(int'(op), sa[k], sb[k]);
      nf = (res[k] >> 7) & 1;
      zf = (res[k] == 0) ? 1 : 0;
      if (vsi == 2'b11 && k > 0) begin
        res[k] = 0; nf = 0; zf = 0;
      end
      flags |= ((nf << 1) | zf) << (2 * k);
    end
    a_exp = 32'(sa[0]) | (32'(sa[1]) << 8) | (32'(sa[2]) << 16) | (32'(sa[3]) << 24);
    #1;
    obs_a = A;
    check("operand_a", A, a_exp);
    step();
    set_ctrl(0, 0, 0, 0, 0, 2'b00, 3'b000);
    step();
    ReadData = rdata;
    check("memwrite_m", 32'(MemWriteM), 32'(mw));
    check("memtoreg_m", 32'(MemtoRegM), 32'(m2r));
    check("aluout_m", 32'(ALUOutM), 32'(res[0]));
    check("writedata_m", 32'(WriteDataM), 32'(b2[0]));
    pend_valid = 1'b1;
    pend_rw = rw; pend_m2r = m2r; pend_fw = fw;
    pend_rd = rdd; pend_flags = flags; pend_rdata = int'(rdata);
    for (int k = 0; k < 6; k++) pend_res[k] = res[k];
  endtask

  function automatic int pick_reg();
    int p;
    p = int'($urandom_range(0, 4));
    return (p == 4) ? 15 : p + 1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] instr;
    reset = 1'b0;
    set_ctrl(0, 0, 0, 0, 0, 2'b00, 3'b000);
    InstrF = 32'h4600_0000;
    ReadData = 32'h0;
    PCNext = 32'h0;
    clear_model();
    step();
    step();
    check_all_zero("reset");

    @(negedge clk);
    reset = 1'b1;
    step();
    check("instr_d_first", InstrD, 32'h4600_0000);

    // Load R1 <- 0x5A
    issue(32'h0000_1000, 1, 1, 0, 0, 0, 2'b00, 3'b000, $urandom, 32'h0000_005A);
    // R2 = R1 + imm 1, operand read hits the write-through of R1
    issue(32'h0001_2001, 1, 0, 0, 0, 0, 2'b10, 3'b000, $urandom, $urandom);
    check("load_then_read_a", obs_a, 32'h0000_005A);
    check("add_imm_aluout", 32'(ALUOutM), 32'h5B);
    // R3 = R1 - R1 with flags
    issue(32'h0001_3001, 1, 0, 0, 1, 0, 2'b00, 3'b001, $urandom, $urandom);
    check("sub_zero_aluout", 32'(ALUOutM), 32'h0);
    // Store R1
    issue(32'h0000_1000, 0, 0, 1, 0, 1, 2'b00, 3'b000, $urandom, $urandom);
    check("sub_zero_flags", obs_flags_prev, 32'h555);
    check("store_memwrite", 32'(MemWriteM), 32'h1);
    check("store_data", 32'(WriteDataM), 32'h5A);

    // Reset while the store sits in M
    reset = 1'b0;
    #1;
    check_all_zero("midpipe_reset");
    clear_model();
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 60; i++) begin
      instr = $urandom;
      instr[19:16] = 4'(pick_reg());
      instr[15:12] = 4'(pick_reg());
      instr[3:0]   = 4'(pick_reg());
      issue(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    InstrF = 32'h0;
    step();
    retire();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
